// File: rtl/key_reader_pkg.sv
// key_reader_pkg: key index constants, display state type and the LED presentation shared with the display side.
package key_reader_pkg;

   localparam int unsigned NUM_KEYS  = 4;
   localparam int unsigned LED_W     = 10;

   localparam int unsigned KEY_CLEAR = 3;
   localparam int unsigned KEY_HOLD  = 2;
   localparam int unsigned KEY_LOAD  = 1;
   localparam int unsigned KEY_STEP  = 0;

   typedef logic [1:0] disp_state_t;

   localparam logic [LED_W-1:0] LEDR_RESET = 10'b00_0000_0001;

   // {s, held levels, one-hot of s}
   function automatic logic [LED_W-1:0] led_decode(input disp_state_t s,
                                                   input logic [NUM_KEYS-1:0] held);
      logic [3:0] onehot;
      onehot = 4'b0001 << s;
      return {s, held, onehot};
   endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, stability counter and press-edge detect for one active-low pushbutton.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic level,
   output logic press_c
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   // Bring the raw pin into the clock domain; idles released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
      end else begin
         sync_a <= key;
         sync_b <= sync_a;
      end
   end

   // Accept the synchronized level only after it has disagreed for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b1;
      end else if (sync_b == level) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         level <= sync_b;
         cnt   <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Previous debounced level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_d <= 1'b1;
      else     level_d <= level;
   end

   assign press_c = level_d & ~level;

endmodule

// File: rtl/key_reader.sv
// key_reader: conditions KEY[3:0] into one-cycle press events and steps/loads/clears a 2-bit display state.
// Optional build macro: KEY_AUTOREPEAT_EN adds auto-repeat on KEY[0] every REPEAT_CYCLES while held.
module key_reader
   import key_reader_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
   input  logic                CLOCK_50,
   input  logic                RESET,
   input  logic [NUM_KEYS-1:0] KEY,
   input  logic [9:0]          SW,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [1:0]          state,
   output logic [LED_W-1:0]    LEDR
);

   logic [NUM_KEYS-1:0] level;
   logic [NUM_KEYS-1:0] press_c;
   logic [NUM_KEYS-1:0] press_next;
   disp_state_t         state_next;

   // One conditioner per pushbutton.
   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (CLOCK_50),
         .rst     (RESET),
         .key     (KEY[i]),
         .level   (level[i]),
         .press_c (press_c[i])
      );
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int unsigned     REP_W    = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt;
   logic             rep_hit;

   assign rep_hit = ~level[KEY_STEP] & ~press_c[KEY_STEP] & (rep_cnt == REP_LAST);

   // Repeat timer: restarts on the initial press, runs while held, clears on release.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET)                                               rep_cnt <= '0;
      else if (level[KEY_STEP] | press_c[KEY_STEP] | rep_hit)  rep_cnt <= '0;
      else                                                     rep_cnt <= rep_cnt + REP_W'(1);
   end

   // Merge repeat events into the step key.
   always_comb begin
      press_next           = press_c;
      press_next[KEY_STEP] = press_c[KEY_STEP] | rep_hit;
   end
`else
   assign press_next = press_c;
`endif

   // SW[7:1] carry no function; REPEAT_CYCLES matters only with auto-repeat.
   logic unused_bits;
   assign unused_bits = ^{SW[7:1], 32'(REPEAT_CYCLES)};

   // Next display state from last cycle's presses, highest-priority key wins.
   always_comb begin
      state_next = state;
      if (key_press[KEY_CLEAR]) begin
         state_next = 2'b00;
      end else if (key_press[KEY_LOAD]) begin
         state_next = SW[9:8];
      end else if (key_press[KEY_STEP]) begin
         state_next = SW[0] ? state - 2'd1 : state + 2'd1;
      end
   end

   // Output registers: press pulses, display state and LED presentation.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         key_press <= '0;
         state     <= 2'b00;
         LEDR      <= LEDR_RESET;
      end else begin
         key_press <= press_next;
         state     <= state_next;
         LEDR      <= led_decode(state_next, ~level);
      end
   end

endmodule
